decode_exec_pipe_stage: RTL

//  Parametrised ID->EX pipeline register with valid/ready handshake, flush and bubble insertion.

---
 rtl/decode_exec_pipe_stage_pkg.sv | 40 ++++
 rtl/decode_exec_pipe_stage_if.sv | 17 +
 rtl/decode_exec_pipe_stage_skid.sv | 29 ++
 rtl/decode_exec_pipe_stage.sv | 99 +++++++++
 4 files changed

// File: rtl/decode_exec_pipe_stage_pkg.sv
// Shared definitions for the ID->EX pipe stage: packed control layout and default widths.
// The control layout is used to pack ctrl in decode and to unpack it in execute.
package decode_exec_pipe_stage_pkg;

  // Field order is MSB first; ctrl width is derived from this layout.
  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd_addr1;
    logic [4:0] rd_addr2;
    logic [4:0] wr_addr;
    logic       reg_wr_en;
    logic       mem_rd_en;
    logic       mem_wr_en;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jump;
    logic       jump_use_r;
    logic [4:0] offset;
  } ctrl_t;

  localparam int CTRL_W          = $bits(ctrl_t);
  localparam int CTRL_OFFSET     = 0;
  localparam int CTRL_JUMP_USE_R = 5;
  localparam int CTRL_JUMP       = 6;
  localparam int CTRL_BRANCH     = 7;
  localparam int CTRL_WB_SEL     = 8;
  localparam int CTRL_MEM_WR_EN  = 10;
  localparam int CTRL_MEM_RD_EN  = 11;
  localparam int CTRL_REG_WR_EN  = 12;
  localparam int CTRL_WR_ADDR    = 13;
  localparam int CTRL_RD_ADDR2   = 18;
  localparam int CTRL_RD_ADDR1   = 23;
  localparam int CTRL_FUNCTION   = 28;
  localparam int CTRL_OPCODE     = 34;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PC_WIDTH   = 20;

endpackage

// File: rtl/decode_exec_pipe_stage_if.sv
// Valid/ready instruction bus between pipeline stages: operands, next PC and control.
// master drives valid and payload, slave drives ready.
interface decode_exec_pipe_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 20,
  parameter int CTRL_WIDTH = 40
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [PC_WIDTH-1:0]   pc;
  logic [CTRL_WIDTH-1:0] ctrl;

  modport master (output valid, alu_a, alu_b, pc, ctrl, input ready);
  modport slave  (input valid, alu_a, alu_b, pc, ctrl, output ready);
endinterface

// File: rtl/decode_exec_pipe_stage_skid.sv
// decode_pipe_skid: one payload register plus valid bit, used as the skid entry
// when DECODE_PIPE_SKID_EN is defined.
module decode_pipe_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // Flush only kills the valid bit; stale payload is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (flush)       valid <= 1'b0;
      else if (load)   valid <= 1'b1;
      else if (unload) valid <= 1'b0;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/decode_exec_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush and bubble (NOP) insertion.
// Define DECODE_PIPE_SKID_EN for a registered in_ready and a second (skid) entry.
module decode_exec_pipe_stage
  import decode_exec_pipe_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int CTRL_WIDTH = CTRL_W
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      flush,
  decode_exec_pipe_stage_if.slave  in_if,
  decode_exec_pipe_stage_if.master out_if
);

  localparam int PW = CTRL_WIDTH + PC_WIDTH + 2 * DATA_WIDTH;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_payload;
  logic [PW-1:0] main_d;
  logic          main_valid;
  logic          main_load;
  logic          main_clear;
  logic          push;
  logic          pop;

  assign in_payload = {in_if.ctrl, in_if.pc, in_if.alu_b, in_if.alu_a};
  assign push       = in_if.valid & in_if.ready;
  assign pop        = main_valid & out_if.ready;

`ifdef DECODE_PIPE_SKID_EN
  logic          skid_valid;
  logic          skid_load;
  logic          skid_unload;
  logic [PW-1:0] skid_payload;

  // in_ready depends only on state, so no combinational path from out_ready.
  assign in_if.ready = ~skid_valid;
  assign skid_load   = push & main_valid & ~pop;
  assign skid_unload = pop & skid_valid;

  decode_pipe_skid #(.WIDTH(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .load   (skid_load),
    .unload (skid_unload),
    .d      (in_payload),
    .q      (skid_payload),
    .valid  (skid_valid)
  );

  // Skid holds the older instruction, so it refills main ahead of new input.
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_d     = in_payload;
    if (skid_unload) begin
      main_load = 1'b1;
      main_d    = skid_payload;
    end else if (push && (!main_valid || pop)) begin
      main_load = 1'b1;
    end else if (pop) begin
      main_clear = 1'b1;
    end
  end
`else
  assign in_if.ready = ~main_valid | out_if.ready;

  always_comb begin
    main_load  = push;
    main_clear = pop & ~push;
    main_d     = in_payload;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid   <= 1'b0;
      main_payload <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (main_load) begin
      main_valid   <= 1'b1;
      main_payload <= main_d;
    end else if (main_clear) begin
      main_valid <= 1'b0;
    end
  end

  // An empty stage presents ctrl = 0, which execute treats as a NOP.
  assign out_if.valid = main_valid;
  assign out_if.alu_a = main_payload[DATA_WIDTH-1:0];
  assign out_if.alu_b = main_payload[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_if.pc    = main_payload[2*DATA_WIDTH+PC_WIDTH-1:2*DATA_WIDTH];
  assign out_if.ctrl  = main_valid ? main_payload[PW-1:PW-CTRL_WIDTH] : '0;

endmodule
